fwd_ctrl_unit: RTL

//  Forwarding/hazard control for the 5-stage pipeline. Tracks destination registers

---
 rtl/fwd_pkg.sv | 25 ++
 rtl/fwd_stage_tag.sv | 18 +
 rtl/fwd_ctrl_unit.sv | 64 ++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared select encodings, stage tag types and forwarding helpers
package fwd_pkg;
  localparam int REG_AW = 5;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } stage_tag_t;
  typedef struct packed {
    stage_tag_t        tag;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              memread;
  } ex_tag_t;
  function automatic logic writes_rs(stage_tag_t t, logic [REG_AW-1:0] rs);
    return t.valid && t.regwrite && t.rd != '0 && t.rd == rs;
  endfunction
  // MEM holds the younger result, so it wins over WB on a double match
  function automatic logic [1:0] fwd_sel(stage_tag_t mem, stage_tag_t wb, logic [REG_AW-1:0] rs);
    return writes_rs(mem, rs) ? FWD_MEM : writes_rs(wb, rs) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/fwd_stage_tag.sv
// fwd_stage_tag: one pipeline tracking register with bubble insert
// Ports: clk_i/rst_n_i clock and async active-low reset, bubble_i loads all-zero
// (valid=0) instead of d_i, d_i next tag, q_o current tag.
module fwd_stage_tag #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_q <= '0;
    else r_q <= bubble_i ? '0 : d_i;
  assign q_o = r_q;
endmodule

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: EX operand forwarding selects and load-use stall detection
// Ports: clk_i, rst_n_i (async active-low); id_* decoded ID instruction; flush_i
// squashes the instruction leaving ID; ex_fwd_a_o/ex_fwd_b_o registered mux selects
// (00 regfile, 01 WB, 10 MEM); hazard_stall_o combinational load-use stall;
// stall_cnt_o saturating stall count when FWD_STALL_CNT_EN is defined, else 0.
module fwd_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        ex_fwd_a_o,
  output logic [1:0]        ex_fwd_b_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  import fwd_pkg::*;
  ex_tag_t    w_ex_d, w_ex_q;
  stage_tag_t w_mem_q, w_wb_q;
  logic       w_ex_bubble;
  logic [1:0] r_fwd_a, r_fwd_b;
  assign hazard_stall_o = id_valid_i && w_ex_q.tag.valid && w_ex_q.memread && w_ex_q.tag.rd != '0 &&
                          (w_ex_q.tag.rd == id_rs1_i || w_ex_q.tag.rd == id_rs2_i);
  assign w_ex_bubble = !id_valid_i || hazard_stall_o || flush_i;
  assign w_ex_d = '{tag: '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i},
                    rs1: id_rs1_i, rs2: id_rs2_i, memread: id_memread_i};
  fwd_stage_tag #(.W($bits(ex_tag_t))) u_ex (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bubble_i(w_ex_bubble), .d_i(w_ex_d), .q_o(w_ex_q)
  );
  fwd_stage_tag #(.W($bits(stage_tag_t))) u_mem (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bubble_i(1'b0), .d_i(w_ex_q.tag), .q_o(w_mem_q)
  );
  fwd_stage_tag #(.W($bits(stage_tag_t))) u_wb (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .bubble_i(1'b0), .d_i(w_mem_q), .q_o(w_wb_q)
  );
  // Selects are computed for the next EX occupant against the next MEM (current EX)
  // and next WB (current MEM), so they are stable for the whole EX cycle.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_fwd_a <= w_ex_bubble ? FWD_REG : fwd_sel(w_ex_q.tag, w_mem_q, id_rs1_i);
      r_fwd_b <= w_ex_bubble ? FWD_REG : fwd_sel(w_ex_q.tag, w_mem_q, id_rs2_i);
    end
  assign ex_fwd_a_o = r_fwd_a;
  assign ex_fwd_b_o = r_fwd_b;
`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_stall_cnt <= '0;
    else if (hazard_stall_o && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule
